// File: rtl/check_parity_pitch_fsm.sv
// check_parity_pitch_fsm: decoder-side pitch parity check over pitch_index[N_BITS+1:2],
// serial one-bit-per-cycle start/done FSM; sum[0]=1 flags a bad pitch.
module check_parity_pitch_fsm #(
    parameter int N_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] pitch_index,
    input  logic [15:0] parity,
    output logic        done,
    output logic        busy,
    output logic [15:0] sum
);
    localparam int CW = $clog2(N_BITS + 1);
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_LOOP, S_PAR, S_DONE} state_t;
    state_t r_state, w_next;
    logic [15:0] r_pitch, r_parity, r_temp, r_acc, r_sum;
    logic [CW-1:0] r_cnt;
    logic r_done, r_busy;
    logic w_last;
    assign w_last = r_cnt == CW'(N_BITS - 1);
    assign done = r_done;
    assign busy = r_busy;
    assign sum = r_sum;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = start ? S_INIT : S_IDLE;
            S_INIT: w_next = S_LOOP;
            S_LOOP: w_next = w_last ? S_PAR : S_LOOP;
            S_PAR:  w_next = S_DONE;
            S_DONE: w_next = start ? S_DONE : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pitch  <= '0;
            r_parity <= '0;
            r_temp   <= '0;
            r_acc    <= '0;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pitch  <= pitch_index;
                        r_parity <= parity;
                        r_busy   <= 1'b1;
                    end
                end
                S_INIT: begin
                    r_temp <= r_pitch >> 1;
                    r_acc  <= 16'd1;
                    r_cnt  <= '0;
                end
                // temp[1] is the bit that (temp >> 1) exposes at position 0
                S_LOOP: begin
                    r_temp <= r_temp >> 1;
                    r_acc  <= r_acc + {15'd0, r_temp[1]};
                    r_cnt  <= r_cnt + 1'b1;
                end
                S_PAR: begin
                    r_sum  <= (r_acc + r_parity) & 16'h0001;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                S_DONE: begin
                    if (!start) r_done <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_check_parity_pitch_fsm.sv
// tb_check_parity_pitch_fsm: table vectors, corner sequences and random ops
// checked against a popcount-based parity model.
module tb_check_parity_pitch_fsm;
    logic clk = 0, reset = 0, start = 0, done, busy;
    logic [15:0] pitch_index = '0, parity = '0, sum;
    int n_cmp = 0, n_bad = 0;

    check_parity_pitch_fsm #(.N_BITS(6)) dut (
        .clk(clk), .reset(reset), .start(start), .pitch_index(pitch_index),
        .parity(parity), .done(done), .busy(busy), .sum(sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pitch;
        logic [15:0] par;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // seed 1 plus the checked pitch bits plus parity bit 0, kept mod 2
    function automatic logic [15:0] model(input logic [15:0] p, input logic [15:0] q);
        int ones;
        ones = $countones(p[7:2]);
        return 16'((1 + ones + int'(q[0])) % 2);
    endfunction

    task automatic op(input logic [15:0] p, input logic [15:0] q, input logic [15:0] e,
                      input int hold, input bit tog, input string nm);
        int k;
        @(negedge clk);
        pitch_index = p;
        parity = q;
        start = 1;
        @(posedge clk); #1;
        chk({nm, "_busy0"}, busy, 1);
        chk({nm, "_done0"}, done, 0);
        pitch_index = 16'($urandom);
        parity = 16'($urandom);
        k = 0;
        while (!done && k < 20) begin
            start = (k + 1 < hold) || (tog && k >= 2 && k <= 4);
            @(posedge clk); #1;
            k++;
        end
        chk({nm, "_lat"}, k, 8);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_sum"}, sum, e);
        if (hold > 9) begin
            start = 1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk({nm, "_hold_done"}, done, 1);
            chk({nm, "_hold_busy"}, busy, 0);
        end
        start = 0;
        @(posedge clk); #1;
        chk({nm, "_idle_done"}, done, 0);
        chk({nm, "_idle_sum"}, sum, e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        logic [15:0] rp, rq;
        vt[0] = '{16'h0000, 16'h0001, 16'h0000};
        vt[1] = '{16'h0000, 16'h0000, 16'h0001};
        vt[2] = '{16'h00FC, 16'h0001, 16'h0000};
        vt[3] = '{16'h00FC, 16'h0000, 16'h0001};
        vt[4] = '{16'hFF03, 16'h0002, 16'h0001};
        vt[5] = '{16'h0004, 16'h0000, 16'h0000};
        #13;
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 6; i++) op(vt[i].pitch, vt[i].par, vt[i].exp, (i == 0) ? 2 : 1, 0, $sformatf("vec%0d", i));

        // reset mid-operation, with sum previously 1
        op(16'hFF03, 16'h0002, 16'h0001, 1, 0, "pre_rst");
        @(negedge clk);
        pitch_index = 16'h00FC;
        parity = 16'h0001;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #2;
        reset = 0;
        #1;
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 0);
        op(16'h0004, 16'h0000, 16'h0000, 1, 0, "fresh");

        // start pulsed during LOOP, then back-to-back with start held
        op(16'h00FC, 16'h0001, 16'h0000, 1, 1, "tog");
        op(16'h00FC, 16'h0000, 16'h0001, 12, 0, "b2b_a");
        op(16'h0004, 16'h0001, 16'h0001, 1, 0, "b2b_b");

        for (int i = 0; i < 40; i++) begin
            rp = 16'($urandom);
            rq = 16'($urandom);
            op(rp, rq, model(rp, rq), int'($urandom_range(1, 3)), bit'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
